// File: rtl/sda_bus_arbiter.sv
// Round-robin arbiter and byte sequencer for the parallel SDA/SCL peripheral bus.
// Optional ack timeout enabled by defining SDA_ARB_TIMEOUT_EN.
module sda_bus_arbiter #(
  parameter int NREQ    = 2,
  parameter int SCL_DIV = 4,
  parameter int ACK_TMO = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   wr,
  input  logic [8*NREQ-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic              done,
  output logic              nack,
  output logic [7:0]        rdata,
  output logic [7:0]        sda_out,
  output logic              sda_oe,
  input  logic [7:0]        sda_in,
  output logic              scl
);

  localparam int PW      = $clog2(NREQ);
  localparam int CNT_MAX = (SCL_DIV > ACK_TMO) ? SCL_DIV : ACK_TMO;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_SETUP, S_STROBE, S_ACK, S_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [PW-1:0]   ptr_reg, ptr_next;
  logic [PW-1:0]   sel_reg, sel_next;
  logic            wr_reg, wr_next;
  logic [7:0]      wdata_reg, wdata_next;
  logic [7:0]      rdata_reg, rdata_next;
  logic            nack_reg, nack_next;

  logic [7:0]      wdata_arr [NREQ];
  logic            win_found;
  logic [PW-1:0]   win_idx;
  int              cand;
  logic            busy;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign wdata_arr[gi] = wdata[8*gi +: 8];
    assign gnt[gi] = (busy && sel_reg == PW'(gi)) ||
                     (state_reg == S_ARB && win_found && win_idx == PW'(gi));
  end

  // Scan from the farthest offset down so the nearest requester after ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = (int'(ptr_reg) + k) % NREQ;
      if (req[cand[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CW'(1);
    ptr_next   = ptr_reg;
    sel_next   = sel_reg;
    wr_next    = wr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    nack_next  = nack_reg;
    case (state_reg)
      S_IDLE: if (|req) state_next = S_ARB;
      S_ARB: begin
        if (win_found) begin
          sel_next   = win_idx;
          wr_next    = wr[win_idx];
          wdata_next = wdata_arr[win_idx];
          nack_next  = 1'b0;
          state_next = S_SETUP;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_SETUP: if (cnt_reg == CW'(SCL_DIV - 1)) state_next = S_STROBE;
      S_STROBE: begin
        if (cnt_reg == CW'(SCL_DIV - 1)) begin
          if (wr_reg) begin
            state_next = S_ACK;
          end else begin
            rdata_next = sda_in;
            state_next = S_DONE;
          end
        end
      end
      S_ACK: begin
        if (!sda_in[0]) begin
          nack_next  = 1'b0;
          state_next = S_DONE;
        end
`ifdef SDA_ARB_TIMEOUT_EN
        else if (cnt_reg == CW'(ACK_TMO - 1)) begin
          nack_next  = 1'b1;
          state_next = S_DONE;
        end
`endif
      end
      S_DONE: begin
        ptr_next   = sel_reg;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (state_next != state_reg) cnt_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      ptr_reg   <= PW'(NREQ - 1);
      sel_reg   <= '0;
      wr_reg    <= 1'b0;
      wdata_reg <= 8'hFF;
      rdata_reg <= 8'h00;
      nack_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ptr_reg   <= ptr_next;
      sel_reg   <= sel_next;
      wr_reg    <= wr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      nack_reg  <= nack_next;
    end
  end

  // Outputs decode from registered state so reset reaches the pads without a clock.
  assign busy    = (state_reg == S_SETUP) || (state_reg == S_STROBE) ||
                   (state_reg == S_ACK)   || (state_reg == S_DONE);
  assign done    = (state_reg == S_DONE);
  assign rdata   = rdata_reg;
  assign scl     = !((state_reg == S_SETUP) || (state_reg == S_ACK));
  assign sda_oe  = wr_reg && ((state_reg == S_SETUP) || (state_reg == S_STROBE));
  assign sda_out = sda_oe ? wdata_reg : 8'hFF;
`ifdef SDA_ARB_TIMEOUT_EN
  assign nack    = done && nack_reg;
`else
  assign nack    = 1'b0;
`endif

endmodule

// File: tb/tb_sda_bus_arbiter.sv
// Self-checking bench for sda_bus_arbiter: directed and random transactions
// checked cycle by cycle against a timeline/round-robin reference model.
module tb_sda_bus_arbiter;
  localparam int NREQ    = 2;
  localparam int S       = 4;
  localparam int ACK_TMO = 16;
  localparam int A       = 3 + 2*S;   // cycle number of ACK entry, counting the IDLE cycle as 1

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req, wr, gnt;
  logic [8*NREQ-1:0] wdata;
  logic              done, nack, sda_oe, scl;
  logic [7:0]        rdata, sda_out, sda_in;

  int         tests = 0;
  int         fails = 0;
  int         txns  = 0;
  int         ptr_m = NREQ - 1;
  logic [7:0] last_rd = 8'h00;

  always #5 clk = ~clk;

  sda_bus_arbiter #(.NREQ(NREQ), .SCL_DIV(S), .ACK_TMO(ACK_TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .wdata(wdata),
    .gnt(gnt), .done(done), .nack(nack), .rdata(rdata),
    .sda_out(sda_out), .sda_oe(sda_oe), .sda_in(sda_in), .scl(scl)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s txn=%0d observed=%0h expected=%0h", tag, txns, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      req = '0;
      #1;
      check("idle_gnt", 32'(gnt), 32'(0));
      check("idle_done", 32'(done), 32'(0));
      check("idle_scl", 32'(scl), 32'(1));
      check("idle_oe", 32'(sda_oe), 32'(0));
    end
  endtask

  // One transaction; its first cycle is the IDLE cycle following the caller's current cycle.
  task automatic run_txn(input logic [NREQ-1:0] reqv, input logic [NREQ-1:0] wrv,
                         input logic [8*NREQ-1:0] wd, input logic [7:0] rd_byte,
                         input int ack_delay, input logic [NREQ-1:0] drop_mask);
    int              win, idx, done_cyc;
    logic [NREQ-1:0] tmp, exp_gnt;
    logic            w, exp_nack, exp_scl, exp_oe;
    logic [7:0]      exp_out, exp_rd;
    win = -1;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (ptr_m + k) % NREQ;
      tmp = reqv >> idx;
      if (win < 0 && tmp[0]) win = idx;
    end
    tmp     = wrv >> win;
    w       = tmp[0];
    exp_out = 8'(wd >> (8*win));
    exp_gnt = NREQ'(1) << win;
    exp_nack = 1'b0;
    if (!w) begin
      done_cyc = A;
    end else begin
      done_cyc = A + ack_delay + 1;
`ifdef SDA_ARB_TIMEOUT_EN
      if (ack_delay >= ACK_TMO) begin
        done_cyc = A + ACK_TMO;
        exp_nack = 1'b1;
      end
`endif
    end
    exp_rd = w ? last_rd : rd_byte;
    for (int cyc = 1; cyc <= done_cyc; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) begin req = reqv; wr = wrv; wdata = wd; end
      if (cyc == 4) req = req & ~drop_mask;
      if (w && cyc >= A)                sda_in = {~rd_byte[7:1], (cyc - A) < ack_delay};
      else if (!w && cyc == 2 + 2*S)    sda_in = rd_byte;
      else                              sda_in = ~rd_byte;
      #1;
      exp_scl = !((cyc >= 3 && cyc <= 2 + S) || (w && cyc >= A && cyc < done_cyc));
      exp_oe  = w && cyc >= 3 && cyc <= 2 + 2*S;
      check("gnt", 32'(gnt), 32'((cyc >= 2) ? exp_gnt : '0));
      check("scl", 32'(scl), 32'(exp_scl));
      check("sda_oe", 32'(sda_oe), 32'(exp_oe));
      check("sda_out", 32'(sda_out), 32'(exp_oe ? exp_out : 8'hFF));
      check("done", 32'(done), 32'(cyc == done_cyc));
      if (cyc == done_cyc) begin
        check("nack", 32'(nack), 32'(exp_nack));
        check("rdata", 32'(rdata), 32'(exp_rd));
      end
    end
    ptr_m   = win;
    last_rd = exp_rd;
    txns++;
    $display("[TB] txn %0d: req=%b winner=%0d %s done_cycle=%0d nack=%b rdata=%02h",
             txns, reqv, win, w ? "write" : "read", done_cyc, exp_nack, exp_rd);
  endtask

  initial begin
    logic [NREQ-1:0]   rq, wv;
    logic [8*NREQ-1:0] wd;
    logic [7:0]        rb;
    rst_n = 1'b0; req = '0; wr = '0; wdata = '0; sda_in = 8'hFF;
    #2;
    check("rst_gnt", 32'(gnt), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_nack", 32'(nack), 32'(0));
    check("rst_rdata", 32'(rdata), 32'(8'h00));
    check("rst_sda_out", 32'(sda_out), 32'(8'hFF));
    check("rst_oe", 32'(sda_oe), 32'(0));
    check("rst_scl", 32'(scl), 32'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_txn(2'b01, 2'b01, 16'h00A5, 8'h00, 0, 2'b00);   // write with immediate ack
    idle(2);
    run_txn(2'b10, 2'b00, 16'h0000, 8'h3C, 0, 2'b00);   // read
    idle(1);
    for (int i = 0; i < 4; i++)                          // both requesting: alternate
      run_txn(2'b11, 2'b11, 16'h1234 + 16'(i), 8'h00, 0, 2'b00);
    run_txn(2'b11, 2'b11, 16'h9966, 8'h00, 0, 2'b01);    // req[0] dropped in SETUP
    run_txn(2'b11, 2'b00, 16'h0000, 8'hC3, 0, 2'b00);    // next follows pointer
    idle(1);
    run_txn(2'b01, 2'b00, 16'h0000, 8'h81, 0, 2'b00);    // sole requester, twice
    run_txn(2'b01, 2'b01, 16'h007E, 8'h00, 0, 2'b00);
    idle(1);
    run_txn(2'b10, 2'b10, 16'hB700, 8'h00, 3, 2'b00);    // late ack
`ifdef SDA_ARB_TIMEOUT_EN
    run_txn(2'b01, 2'b01, 16'h0011, 8'h00, ACK_TMO - 1, 2'b00);
    idle(1);
    run_txn(2'b10, 2'b10, 16'h2200, 8'h00, 100, 2'b00);
`else
    run_txn(2'b01, 2'b01, 16'h0011, 8'h00, 30, 2'b00);
`endif
    idle(1);
    for (int i = 0; i < 8; i++) begin
      rq = NREQ'($urandom_range(1, 3));
      wv = NREQ'($urandom);
      wd = 16'($urandom);
      rb = 8'($urandom);
      run_txn(rq, wv, wd, rb, $urandom_range(0, 3), 2'b00);
    end
    idle(1);
    run_txn(2'b01, 2'b01, 16'h0042, 8'h00, 0, 2'b00);    // leaves ptr at 0

    // Asynchronous reset in the middle of STROBE
    @(posedge clk); #1;
    req = 2'b01; wr = 2'b01; wdata = 16'h005A; sda_in = 8'hFF;
    repeat (7) @(posedge clk);
    #3;
    check("pre_rst_oe", 32'(sda_oe), 32'(1));
    check("pre_rst_sda_out", 32'(sda_out), 32'(8'h5A));
    rst_n = 1'b0;
    #1;
    check("arst_gnt", 32'(gnt), 32'(0));
    check("arst_scl", 32'(scl), 32'(1));
    check("arst_oe", 32'(sda_oe), 32'(0));
    check("arst_sda_out", 32'(sda_out), 32'(8'hFF));
    check("arst_done", 32'(done), 32'(0));
    check("arst_rdata", 32'(rdata), 32'(8'h00));
    req = '0;
    #1;
    rst_n   = 1'b1;
    ptr_m   = NREQ - 1;
    last_rd = 8'h00;
    idle(2);
    run_txn(2'b11, 2'b01, 16'h00E1, 8'h00, 0, 2'b00);    // pointer back at reset value

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
